// File: rtl/stream_mux_n.sv
// stream_mux_n: N-channel valid/ready mux, external select (MODE=0) or round-robin (MODE=1), one output register.
// Latency: a word accepted at edge k is presented on out_* right after edge k (1 cycle).
// Backpressure: in_ready only to the granted channel while the output slot is empty or draining; comb out_ready -> in_ready.
module stream_mux_n #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = 0,
    localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data_i,
    input  logic [N-1:0]         in_valid_i,
    output logic [N-1:0]         in_ready_o,
    input  logic [SELW-1:0]      sel_i,
    output logic [WIDTH-1:0]     out_data_o,
    output logic [SELW-1:0]      out_chan_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    // Last granted channel; the search for the next grant starts just above it.
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

    logic             load_ok;
    logic             grant_vld;
    logic [SELW-1:0]  grant;
    logic [SELW-1:0]  idx;
    logic [WIDTH-1:0] grant_data;
    logic             xfer_in;

    // Output slot can take a new word if empty or being drained this cycle.
    assign load_ok = !out_valid_q | out_ready_i;

    // Grant selection: external select, or first valid channel after rr_ptr (with wrap).
    // In MODE=1 the loop walks from the lowest priority to the highest so the
    // highest-priority valid channel is the last one written.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        idx       = '0;
        if (MODE == 0) begin
            if (int'(sel_i) < N) begin
                grant_vld = 1'b1;
                grant     = sel_i;
            end
        end else begin
            for (int k = N; k >= 1; k--) begin
                idx = SELW'((int'(rr_ptr_q) + k) % N);
                if (in_valid_i[idx]) begin
                    grant_vld = 1'b1;
                    grant     = idx;
                end
            end
        end
    end

    // Data mux for the granted channel, constant slice indices only.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SELW'(i)) begin
                grant_data = in_data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    // Ready goes to the granted channel regardless of its valid (ready-before-valid), never during reset.
    always_comb begin
        in_ready_o = '0;
        for (int i = 0; i < N; i++) begin
            in_ready_o[i] = load_ok & grant_vld & (grant == SELW'(i)) & !rst;
        end
    end

    assign xfer_in = grant_vld & in_valid_i[grant] & load_ok & !rst;

    // Next state: load replaces (or fills) the slot; a drain without load empties it but keeps data/chan.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer_in) begin
            out_data_d  = grant_data;
            out_chan_d  = grant;
            out_valid_d = 1'b1;
            if (MODE != 0) begin
                rr_ptr_d = grant;
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset drops any held word and gives channel 0 first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= SELW'(N - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_chan_o  = out_chan_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: external-select (N=4 and N=3) and round-robin (N=4) instances.
// Expected words are queued by the stimulus; per-instance monitors pop on every output handshake.
// Direct checks cover reset, ready signalling, stall and hold behaviour.
module tb_stream_mux_n;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  c;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: MODE=0, N=4
    logic [127:0] a_in_data;
    logic [3:0]   a_in_valid, a_in_ready;
    logic [1:0]   a_sel, a_out_chan;
    logic [31:0]  a_out_data;
    logic         a_out_valid, a_out_ready;
    // Instance B: MODE=1, N=4
    logic [127:0] b_in_data;
    logic [3:0]   b_in_valid, b_in_ready;
    logic [1:0]   b_sel, b_out_chan;
    logic [31:0]  b_out_data;
    logic         b_out_valid, b_out_ready;
    // Instance C: MODE=0, N=3 (sel=3 is out of range)
    logic [95:0]  c_in_data;
    logic [2:0]   c_in_valid, c_in_ready;
    logic [1:0]   c_sel, c_out_chan;
    logic [31:0]  c_out_data;
    logic         c_out_valid, c_out_ready;

    stream_mux_n #(.WIDTH(32), .N(4), .MODE(0)) dut_a (
        .clk(clk), .rst(rst), .in_data_i(a_in_data), .in_valid_i(a_in_valid),
        .in_ready_o(a_in_ready), .sel_i(a_sel), .out_data_o(a_out_data),
        .out_chan_o(a_out_chan), .out_valid_o(a_out_valid), .out_ready_i(a_out_ready));

    stream_mux_n #(.WIDTH(32), .N(4), .MODE(1)) dut_b (
        .clk(clk), .rst(rst), .in_data_i(b_in_data), .in_valid_i(b_in_valid),
        .in_ready_o(b_in_ready), .sel_i(b_sel), .out_data_o(b_out_data),
        .out_chan_o(b_out_chan), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready));

    stream_mux_n #(.WIDTH(32), .N(3), .MODE(0)) dut_c (
        .clk(clk), .rst(rst), .in_data_i(c_in_data), .in_valid_i(c_in_valid),
        .in_ready_o(c_in_ready), .sel_i(c_sel), .out_data_o(c_out_data),
        .out_chan_o(c_out_chan), .out_valid_o(c_out_valid), .out_ready_i(c_out_ready));

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: sample at the falling edge, where inputs and outputs are stable.
    always @(negedge clk) begin
        if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected: got data %0h chan %0d with nothing expected", a_out_data, a_out_chan);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_out_data", a_out_data, e.d);
                chk("a_out_chan", a_out_chan, e.c);
            end
        end
    end

    always @(negedge clk) begin
        if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected: got data %0h chan %0d with nothing expected", b_out_data, b_out_chan);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_out_data", b_out_data, e.d);
                chk("b_out_chan", b_out_chan, e.c);
            end
        end
    end

    always @(negedge clk) begin
        if (c_out_valid && c_out_ready) begin
            if (qc.size() == 0) begin
                checks++; errors++;
                $display("FAIL c_unexpected: got data %0h chan %0d with nothing expected", c_out_data, c_out_chan);
            end else begin
                exp_t e;
                e = qc.pop_front();
                chk("c_out_data", c_out_data, e.d);
                chk("c_out_chan", c_out_chan, e.c);
            end
        end
    end

    initial begin
        // ---- Reset with every channel valid ----
        rst = 1'b1;
        a_in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        b_in_data = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        c_in_data = {32'hC2, 32'hC1, 32'hC0};
        a_in_valid = 4'b1111; b_in_valid = 4'b1111; c_in_valid = 3'b111;
        a_sel = 2'd0; b_sel = 2'd0; c_sel = 2'd0;
        a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
        #1;
        chk("rst_a_in_ready_pre", a_in_ready, 4'b0000);
        chk("rst_b_in_ready_pre", b_in_ready, 4'b0000);
        for (int r = 0; r < 2; r++) begin
            step();
            chk("rst_a_out_valid", a_out_valid, 1'b0);
            chk("rst_a_out_data", a_out_data, 32'h0);
            chk("rst_a_out_chan", a_out_chan, 2'd0);
            chk("rst_a_in_ready", a_in_ready, 4'b0000);
            chk("rst_b_out_valid", b_out_valid, 1'b0);
            chk("rst_b_in_ready", b_in_ready, 4'b0000);
            chk("rst_c_in_ready", c_in_ready, 3'b000);
        end
        rst = 1'b0;
        a_in_valid = 4'b0000; b_in_valid = 4'b0000; c_in_valid = 3'b000;

        // ---- MODE=0 basic transfer from channel 2 ----
        a_in_data[2*32 +: 32] = 32'hDEAD_BEEF;
        a_sel = 2'd2; a_in_valid = 4'b0100;
        #1;
        chk("sel2_in_ready", a_in_ready, 4'b0100);
        qa.push_back('{d: 32'hDEAD_BEEF, c: 2'd2});
        step();
        a_in_valid = 4'b0000;
        #1;
        chk("sel2_out_valid", a_out_valid, 1'b1);
        step();
        chk("sel2_drained_valid", a_out_valid, 1'b0);
        chk("sel2_hold_data", a_out_data, 32'hDEAD_BEEF);
        chk("sel2_hold_chan", a_out_chan, 2'd2);
        // Ready is offered to the selected channel before it has a word.
        a_sel = 2'd1;
        #1;
        chk("ready_before_valid", a_in_ready, 4'b0010);

        // ---- MODE=0 backpressure ----
        a_in_data[0 +: 32] = 32'h1;
        a_sel = 2'd0; a_in_valid = 4'b0001; a_out_ready = 1'b0;
        #1;
        chk("bp_load_ready", a_in_ready, 4'b0001);
        qa.push_back('{d: 32'h1, c: 2'd0});
        step();
        a_in_data[1*32 +: 32] = 32'h22;
        a_sel = 2'd1; a_in_valid = 4'b0010;
        #1;
        chk("bp_stall_ready", a_in_ready, 4'b0000);
        chk("bp_stall_data", a_out_data, 32'h1);
        step();
        chk("bp_stall2_data", a_out_data, 32'h1);
        chk("bp_stall2_valid", a_out_valid, 1'b1);
        chk("bp_stall2_ready", a_in_ready, 4'b0000);
        a_out_ready = 1'b1;
        #1;
        chk("bp_release_ready", a_in_ready, 4'b0010);
        qa.push_back('{d: 32'h22, c: 2'd1});
        step();
        a_in_valid = 4'b0000;
        #1;
        chk("bp_new_word", a_out_data, 32'h22);
        chk("bp_new_valid", a_out_valid, 1'b1);
        step();
        chk("bp_drained", a_out_valid, 1'b0);

        // ---- MODE=0 out-of-range select (N=3, sel=3) ----
        c_in_data[1*32 +: 32] = 32'hC1;
        c_sel = 2'd1; c_in_valid = 3'b111;
        qc.push_back('{d: 32'hC1, c: 2'd1});
        step();
        c_sel = 2'd3;
        #1;
        chk("oor_in_ready", c_in_ready, 3'b000);
        step();
        chk("oor_drain_valid", c_out_valid, 1'b0);
        chk("oor_hold_data", c_out_data, 32'hC1);
        step();
        chk("oor_no_xfer_valid", c_out_valid, 1'b0);
        chk("oor_in_ready2", c_in_ready, 3'b000);
        c_in_valid = 3'b000;

        // ---- MODE=1 fairness: all valid, grants 0,1,2,3,0,1,2,3 ----
        b_in_data = {32'd3, 32'd2, 32'd1, 32'd0};
        b_in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            qb.push_back('{d: 32'(i % 4), c: 2'(i % 4)});
            step();
        end
        b_in_valid = 4'b0000;
        step();
        chk("rr_drained", b_out_valid, 1'b0);

        // ---- MODE=1 sparse valid from rr_ptr=1, then reset mid-stream ----
        b_in_data = {32'h33, 32'h0, 32'h11, 32'h0};
        b_in_valid = 4'b0010;
        qb.push_back('{d: 32'h11, c: 2'd1});
        step();
        b_in_valid = 4'b1010;
        #1;
        chk("rr_sparse_grant3", b_in_ready, 4'b1000);
        qb.push_back('{d: 32'h33, c: 2'd3});
        step();
        chk("rr_sparse_grant1", b_in_ready, 4'b0010);
        qb.push_back('{d: 32'h11, c: 2'd1});
        step();
        chk("rr_sparse_grant3b", b_in_ready, 4'b1000);
        b_out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rr_rst_in_ready", b_in_ready, 4'b0000);
        qb.delete();
        step();
        chk("rr_rst_out_valid", b_out_valid, 1'b0);
        chk("rr_rst_in_ready2", b_in_ready, 4'b0000);
        rst = 1'b0;
        b_out_ready = 1'b1;
        #1;
        chk("rr_after_rst_grant", b_in_ready, 4'b0010);
        qb.push_back('{d: 32'h11, c: 2'd1});
        step();
        b_in_valid = 4'b0000;
        step();
        step();

        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);
        chk("qc_empty", qc.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
